// File: rtl/ps2_rx_if.sv
// ----------------------------------------------------------------------------
// ps2_rx_if -- signal bundle between a PS/2 device side and the receiver.
//
// Signals:
//   ps2_clk  : PS/2 clock line from the device (asynchronous to clk)
//   ps2_data : PS/2 data line from the device (asynchronous to clk)
//   data     : last correctly received scan code
//   rdy      : one-cycle strobe, data is new and valid this cycle
//   err      : one-cycle strobe, a frame was discarded
//
// Modports:
//   master : device/consumer side, drives the PS/2 lines and observes results
//   slave  : receiver side, samples the PS/2 lines and drives results
// ----------------------------------------------------------------------------
interface ps2_rx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] data;
    logic       rdy;
    logic       err;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  data,
        input  rdy,
        input  err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output data,
        output rdy,
        output err
    );
endinterface

// File: rtl/ps2_rx.sv
// ----------------------------------------------------------------------------
// ps2_rx -- PS/2 device-to-host frame receiver.
//
// Synchronizes the PS/2 lines, debounces the clock line with a FILT-deep
// equality filter, and decodes 11-bit frames (start, 8 data LSB-first, odd
// parity, stop) on filtered falling edges. A frame stalled for TIMEOUT clk
// cycles is aborted.
//
// Parameters:
//   FILT    : consecutive equal clock samples needed to move the filtered level
//   TIMEOUT : clk cycles without a falling edge before a frame is aborted
//
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : ps2_rx_if.slave (ps2_clk/ps2_data in, data/rdy/err out)
// ----------------------------------------------------------------------------
module ps2_rx #(
    parameter int unsigned FILT    = 8,
    parameter int unsigned TIMEOUT = 20000
) (
    input  logic        clk,
    input  logic        rst,
    ps2_rx_if.slave     bus
);

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } state_t;

    localparam logic [19:0] TimeoutCnt = 20'(TIMEOUT);

    // Synchronizers and clock filter.
    logic [1:0]      r_clk_sync;
    logic [1:0]      r_dat_sync;
    logic [FILT-1:0] r_hist;
    logic            r_fclk;

    // Frame decoder.
    state_t          r_state;
    logic [7:0]      r_shift;
    logic [2:0]      r_bitcnt;
    logic            r_par;
    logic [19:0]     r_idle;
    logic [7:0]      r_data;
    logic            r_rdy;
    logic            r_err;

    logic            w_clk_s;
    logic            w_dat_s;
    logic            w_all_lo;
    logic            w_all_hi;
    logic            w_fall;

    assign w_clk_s  = r_clk_sync[1];
    assign w_dat_s  = r_dat_sync[1];
    assign w_all_lo = (r_hist == '0);
    assign w_all_hi = &r_hist;
    // The cycle in which fclk drops from 1 to 0.
    assign w_fall   = r_fclk & w_all_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_hist     <= '1;
            r_fclk     <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[0], bus.ps2_clk};
            r_dat_sync <= {r_dat_sync[0], bus.ps2_data};
            r_hist     <= {r_hist[FILT-2:0], w_clk_s};
            if (w_all_lo) begin
                r_fclk <= 1'b0;
            end else if (w_all_hi) begin
                r_fclk <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_shift  <= 8'h00;
            r_bitcnt <= 3'd0;
            r_par    <= 1'b0;
            r_idle   <= 20'd0;
            r_data   <= 8'h00;
            r_rdy    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            r_err <= 1'b0;
            if (r_state == StIdle) begin
                r_idle <= 20'd0;
                // A high sample here is not a start bit; it is silently ignored.
                if (w_fall && !w_dat_s) begin
                    r_bitcnt <= 3'd0;
                    r_state  <= StData;
                end
            end else if (w_fall) begin
                // An edge wins over a simultaneous timeout.
                r_idle <= 20'd0;
                unique case (r_state)
                    StData: begin
                        r_shift  <= {w_dat_s, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            r_state <= StParity;
                        end
                    end
                    StParity: begin
                        r_par   <= w_dat_s;
                        r_state <= StStop;
                    end
                    StStop: begin
                        r_state <= StIdle;
                        // Odd parity over data plus parity bit, stop bit high.
                        if (w_dat_s && (^{r_shift, r_par})) begin
                            r_data <= r_shift;
                            r_rdy  <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end else if (r_idle == TimeoutCnt) begin
                r_state <= StIdle;
                r_idle  <= 20'd0;
                r_err   <= 1'b1;
            end else begin
                r_idle <= r_idle + 20'd1;
            end
        end
    end

    assign bus.data = r_data;
    assign bus.rdy  = r_rdy;
    assign bus.err  = r_err;

endmodule

// File: tb/tb_ps2_rx.sv
// ----------------------------------------------------------------------------
// tb_ps2_rx -- self-checking bench for ps2_rx.
//
// clk runs at 1 MHz so a 40 us PS/2 bit period is 40 clk cycles. The model
// is a queue of expected result events (good code or discarded frame) built
// from the frame contents; a compare process checks every cycle's outputs
// against it, including the output latency after the stop edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ps2_rx;

    localparam int unsigned FILT    = 8;
    localparam int unsigned TIMEOUT = 20000;
    // 2 synchronizer flops + FILT filter samples + 1 output register.
    localparam longint      LAT     = 3 + FILT;

    typedef struct {
        bit         is_err;
        logic [7:0] d;
        bit         chk_lat;
    } ev_t;

    logic clk;
    logic rst;

    ps2_rx_if bus ();

    ps2_rx #(
        .FILT    (FILT),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         checks;
    int         errors;
    longint     cyc;
    longint     fall_cyc;
    bit         started;
    ev_t        exp_q[$];
    logic [7:0] m_data;
    logic [7:0] rx_log[$];
    int         n_rdy;
    int         n_err;

    initial clk = 1'b0;
    always #500 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Compare process: outputs are checked every cycle outside reset.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (started && !rst) begin
                checks = checks + 1;
                if (bus.rdy && bus.err) begin
                    errors = errors + 1;
                    $display("FAIL rdy_err_both actual=11 required=not_both");
                end
                if (bus.rdy || bus.err) begin
                    checks = checks + 1;
                    if (exp_q.size() == 0) begin
                        errors = errors + 1;
                        $display("FAIL unexpected_strobe actual rdy=%0b err=%0b required none",
                                 bus.rdy, bus.err);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.is_err != bus.err) begin
                            errors = errors + 1;
                            $display("FAIL strobe_kind actual err=%0b required err=%0b",
                                     bus.err, e.is_err);
                        end else if (!e.is_err) begin
                            m_data = e.d;
                        end
                        if (e.chk_lat) begin
                            chk("strobe_latency", 32'(cyc - fall_cyc), 32'(LAT));
                        end
                    end
                    if (bus.rdy) begin
                        n_rdy = n_rdy + 1;
                        rx_log.push_back(bus.data);
                    end
                    if (bus.err) n_err = n_err + 1;
                end
                chk("data_hold", {24'd0, bus.data}, {24'd0, m_data});
            end
        end
    end

    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One PS/2 bit: data changes mid-high, clock low 20 cycles.
    task automatic ps2_bit(input bit b);
        bus.ps2_data = b;
        cyc_wait(10);
        bus.ps2_clk = 1'b0;
        fall_cyc = cyc;
        cyc_wait(20);
        bus.ps2_clk = 1'b1;
        cyc_wait(10);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit flip_par);
        ev_t e;
        bit  p;
        p = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
        p = p ^ flip_par;
        e.is_err  = ($countones({d, p}) % 2) == 0;
        e.d       = d;
        e.chk_lat = 1'b1;
        exp_q.push_back(e);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(p);
        ps2_bit(1'b1);
        bus.ps2_data = 1'b1;
    endtask

    task automatic send_partial(input logic [7:0] d, input int nbits);
        ps2_bit(1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(d[i]);
        bus.ps2_data = 1'b1;
    endtask

    task automatic drained(input string name);
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    function automatic logic [7:0] last_rx(input int back);
        logic [7:0] v;
        v = 8'hxx;
        if (rx_log.size() > back) v = rx_log[rx_log.size() - 1 - back];
        return v;
    endfunction

    initial begin
        ev_t e;
        checks       = 0;
        errors       = 0;
        started      = 1'b0;
        n_rdy        = 0;
        n_err        = 0;
        m_data       = 8'h00;
        fall_cyc     = 0;
        rst          = 1'b1;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        cyc_wait(3);
        chk("reset_data", {24'd0, bus.data}, 32'h00);
        chk("reset_rdy", {31'd0, bus.rdy}, 32'd0);
        chk("reset_err", {31'd0, bus.err}, 32'd0);
        rst     = 1'b0;
        started = 1'b1;
        cyc_wait(20);

        // Good frame 0x1C, parity 0.
        send_frame(8'h1C, 1'b0);
        drained("good_1c_drained");
        chk("good_1c_data", {24'd0, last_rx(0)}, 32'h1C);
        chk("good_1c_nrdy", 32'(n_rdy), 32'd1);
        chk("good_1c_nerr", 32'(n_err), 32'd0);

        // Same frame with parity 1.
        cyc_wait(30);
        send_frame(8'h1C, 1'b1);
        drained("parity_drained");
        chk("parity_nerr", 32'(n_err), 32'd1);
        chk("parity_nrdy", 32'(n_rdy), 32'd1);
        chk("parity_data_kept", {24'd0, bus.data}, 32'h1C);

        // Clock glitch of FILT-1 cycles while idle, then frame 0xF0.
        cyc_wait(30);
        bus.ps2_clk = 1'b0;
        cyc_wait(FILT - 1);
        bus.ps2_clk = 1'b1;
        cyc_wait(40);
        chk("glitch_nrdy", 32'(n_rdy), 32'd1);
        chk("glitch_nerr", 32'(n_err), 32'd1);
        send_frame(8'hF0, 1'b0);
        drained("f0_drained");
        chk("f0_data", {24'd0, last_rx(0)}, 32'hF0);

        // Timeout after start + 3 data bits, then frame 0x5A.
        cyc_wait(30);
        e.is_err  = 1'b1;
        e.d       = 8'h00;
        e.chk_lat = 1'b0;
        exp_q.push_back(e);
        send_partial(8'h5A, 3);
        cyc_wait(TIMEOUT + 10);
        drained("timeout_drained");
        chk("timeout_nerr", 32'(n_err), 32'd2);
        send_frame(8'h5A, 1'b0);
        drained("5a_drained");
        chk("5a_data", {24'd0, last_rx(0)}, 32'h5A);
        chk("5a_nrdy", 32'(n_rdy), 32'd3);

        // Reset after 5 data bits, then frame 0x29.
        cyc_wait(30);
        send_partial(8'h33, 5);
        rst    = 1'b1;
        m_data = 8'h00;
        cyc_wait(1);
        rst = 1'b0;
        cyc_wait(20);
        chk("rst_mid_data", {24'd0, bus.data}, 32'h00);
        send_frame(8'h29, 1'b0);
        drained("29_drained");
        chk("29_data", {24'd0, last_rx(0)}, 32'h29);
        chk("29_nrdy", 32'(n_rdy), 32'd4);
        chk("29_nerr", 32'(n_err), 32'd2);

        // Back-to-back 0xE0 then 0x75, 50 us gap.
        cyc_wait(30);
        send_frame(8'hE0, 1'b0);
        cyc_wait(50);
        send_frame(8'h75, 1'b0);
        drained("b2b_drained");
        chk("b2b_first", {24'd0, last_rx(1)}, 32'hE0);
        chk("b2b_second", {24'd0, last_rx(0)}, 32'h75);
        chk("b2b_nrdy", 32'(n_rdy), 32'd6);
        chk("b2b_nerr", 32'(n_err), 32'd2);

        cyc_wait(20);
        drained("final_drained");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
